// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants and types for the interrupt controller
package irq_pkg;

  localparam int NUM_IRQ = 3;
  localparam int ID_W    = 2;

  // Byte offsets of the registers inside the 16-byte block
  localparam logic [3:0] OFF_MASK  = 4'h0;
  localparam logic [3:0] OFF_PEND  = 4'h4;
  localparam logic [3:0] OFF_INSVC = 4'h8;
  localparam logic [3:0] OFF_CUR   = 4'hC;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_SVC  = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// rtl/irq_controller_if.sv - data-memory bus and core handshake signals of the interrupt controller
interface irq_controller_if;

  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wd;
  logic [31:0] irq_rd;
  logic        irq_req;
  logic [31:0] irq_vec;
  logic        irq_ack;
  logic        irq_eret;

  // Core / bus side
  modport master (
    output dmem_we, dmem_addr, dmem_wd, irq_ack, irq_eret,
    input  irq_rd, irq_req, irq_vec
  );

  // Interrupt controller side
  modport slave (
    input  dmem_we, dmem_addr, dmem_wd, irq_ack, irq_eret,
    output irq_rd, irq_req, irq_vec
  );

endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - fixed-priority encoder, lowest index wins
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id
);

  // Scan from the top down so the lowest set index is the last one written
  always_comb begin
    valid = |req;
    id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - edge-detected, masked, single-level interrupt sequencer with register block
module irq_controller
  import irq_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_0000,
  parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
  parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] IRQ,
  irq_controller_if.slave    bus
);

  logic [NUM_IRQ-1:0] irq_hist_q;
  logic [NUM_IRQ-1:0] mask_q;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] insvc_q;
  logic [ID_W-1:0]    id_q;
  irq_state_e         state_q;
  logic               req_q;
  logic [31:0]        vec_q;

  logic               sel;
  logic [3:0]         off;
  logic               mask_wr;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] w1c;
  logic [NUM_IRQ-1:0] id_onehot;
  logic [NUM_IRQ-1:0] ack_clr;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic               unused_wd_bits;

  assign sel       = (bus.dmem_addr[31:4] == BASE_ADDR[31:4]);
  assign off       = bus.dmem_addr[3:0];
  assign mask_wr   = bus.dmem_we && sel && (off == OFF_MASK);
  assign rise      = IRQ & ~irq_hist_q;
  assign w1c       = (bus.dmem_we && sel && (off == OFF_PEND)) ? bus.dmem_wd[NUM_IRQ-1:0] : '0;
  assign id_onehot = NUM_IRQ'(1) << id_q;
  assign ack_clr   = (state_q == ST_REQ && bus.irq_ack) ? id_onehot : '0;

  assign unused_wd_bits = ^bus.dmem_wd[31:NUM_IRQ];

  irq_prio_enc u_prio_enc (
    .req   (pend_q & mask_q),
    .valid (win_valid),
    .id    (win_id)
  );

  // Edge history, mask register and pending bits; a new edge beats any clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irq_hist_q <= '0;
      mask_q     <= '0;
      pend_q     <= '0;
    end else begin
      irq_hist_q <= IRQ;
      if (mask_wr) mask_q <= bus.dmem_wd[NUM_IRQ-1:0];
      pend_q <= (pend_q & ~w1c & ~ack_clr) | rise;
    end
  end

  // Request/acknowledge/return sequencing with registered request and vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      insvc_q <= '0;
      req_q   <= 1'b0;
      vec_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_valid) begin
            id_q    <= win_id;
            vec_q   <= VEC_BASE + VEC_STRIDE * 32'(win_id);
            req_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus.irq_ack) begin
            insvc_q <= id_onehot;
            req_q   <= 1'b0;
            state_q <= ST_SVC;
          end
        end
        ST_SVC: begin
          if (bus.irq_eret) begin
            insvc_q <= '0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          req_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Zero-latency register readback; anything unmapped reads as zero
  always_comb begin
    bus.irq_rd = '0;
    if (sel) begin
      case (off)
        OFF_MASK:  bus.irq_rd = 32'(mask_q);
        OFF_PEND:  bus.irq_rd = 32'(pend_q);
        OFF_INSVC: bus.irq_rd = 32'(insvc_q);
        OFF_CUR:   bus.irq_rd = 32'({state_q != ST_IDLE, 1'b0, id_q});
        default:   bus.irq_rd = '0;
      endcase
    end
  end

  assign bus.irq_req = req_q;
  assign bus.irq_vec = vec_q;

endmodule

// File: tb/tb_irq_controller.sv
// tb/tb_irq_controller.sv - self-checking bench for irq_controller
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'hFFFF_0000;
  localparam logic [31:0] VB   = 32'h0000_0100;
  localparam logic [31:0] VS   = 32'h0000_0010;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] irq;

  irq_controller_if bus();

  irq_controller #(
    .BASE_ADDR  (BASE),
    .VEC_BASE   (VB),
    .VEC_STRIDE (VS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .IRQ   (irq),
    .bus   (bus)
  );

  always #10 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference: stage 0 = waiting for work, 1 = requesting, 2 = handler running
  logic [2:0]  m_mask, m_pend, m_insvc, m_hist;
  int          m_stage, m_id;
  logic [31:0] m_vec;

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (a == BASE)         return {29'b0, m_mask};
    if (a == BASE + 32'h4) return {29'b0, m_pend};
    if (a == BASE + 32'h8) return {29'b0, m_insvc};
    if (a == BASE + 32'hC) return 32'(m_id) + ((m_stage != 0) ? 32'd8 : 32'd0);
    return 32'd0;
  endfunction

  always @(posedge clk) begin : ref_model
    logic [2:0] clr, act;
    if (!rst_n) begin
      m_mask = 0; m_pend = 0; m_insvc = 0; m_hist = 0;
      m_stage = 0; m_id = 0; m_vec = 0;
    end else begin
      clr = 0;
      act = m_pend & m_mask;
      if (bus.dmem_we && bus.dmem_addr == BASE + 32'h4) clr = bus.dmem_wd[2:0];
      if (m_stage == 1 && bus.irq_ack) begin
        clr[m_id] = 1'b1;
        m_insvc = 0;
        m_insvc[m_id] = 1'b1;
        m_stage = 2;
      end else if (m_stage == 2 && bus.irq_eret) begin
        m_insvc = 0;
        m_stage = 0;
      end else if (m_stage == 0 && act != 0) begin
        for (int i = 2; i >= 0; i--) if (act[i]) m_id = i;
        m_vec = VB + 32'(m_id) * VS;
        m_stage = 1;
      end
      if (bus.dmem_we && bus.dmem_addr == BASE) m_mask = bus.dmem_wd[2:0];
      m_pend = (m_pend & ~clr) | (irq & ~m_hist);
      m_hist = irq;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("req", 32'(bus.irq_req), 32'(m_stage == 1));
    chk("vec", bus.irq_vec, m_vec);
    chk("rd", bus.irq_rd, m_read(bus.dmem_addr));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] data);
    bus.dmem_we = 1'b1; bus.dmem_addr = BASE + off; bus.dmem_wd = data;
    tick();
    bus.dmem_we = 1'b0;
  endtask

  task automatic lit(input string nm, input logic [31:0] off, input logic [31:0] exp);
    bus.dmem_addr = BASE + off;
    #1;
    chk(nm, bus.irq_rd, exp);
    chk({nm, "_model"}, m_read(BASE + off), exp);
  endtask

  task automatic lreq(input string nm, input logic exp);
    chk(nm, 32'(bus.irq_req), 32'(exp));
    chk({nm, "_model"}, 32'(m_stage == 1), 32'(exp));
  endtask

  task automatic lvec(input string nm, input logic [31:0] exp);
    chk(nm, bus.irq_vec, exp);
    chk({nm, "_model"}, m_vec, exp);
  endtask

  task automatic pulse_ack();
    bus.irq_ack = 1'b1; tick(); bus.irq_ack = 1'b0;
  endtask

  task automatic pulse_eret();
    bus.irq_eret = 1'b1; tick(); bus.irq_eret = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq = 3'b000;
    bus.dmem_we = 1'b0; bus.dmem_addr = 32'd0; bus.dmem_wd = 32'd0;
    bus.irq_ack = 1'b0; bus.irq_eret = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    lit("rst_mask", 32'h0, 32'h0);
    lit("rst_pend", 32'h4, 32'h0);
    lit("rst_insvc", 32'h8, 32'h0);
    lit("rst_cur", 32'hC, 32'h0);
    lreq("rst_req", 1'b0);
    lvec("rst_vec", 32'h0);

    // single source, full handshake
    wr(32'h0, 32'h7);
    irq = 3'b010; tick(); irq = 3'b000;
    lreq("irq1_after_e0", 1'b0);
    tick();
    lreq("irq1_req", 1'b1);
    lvec("irq1_vec", 32'h110);
    pulse_ack();
    lreq("ack_drop", 1'b0);
    lit("ack_pend", 32'h4, 32'h0);
    lit("ack_insvc", 32'h8, 32'h2);
    lit("ack_cur", 32'hC, 32'h9);
    pulse_eret();
    lit("eret_insvc", 32'h8, 32'h0);
    lit("eret_cur", 32'hC, 32'h1);

    // two simultaneous sources, priority then the leftover
    irq = 3'b101; tick(); irq = 3'b000; tick();
    lreq("two_req", 1'b1);
    lvec("two_vec0", 32'h100);
    pulse_ack();
    pulse_eret();
    lreq("two_gap", 1'b0);
    lit("two_pend", 32'h4, 32'h4);
    tick();
    lreq("two_req2", 1'b1);
    lvec("two_vec2", 32'h120);
    pulse_ack();
    pulse_eret();

    // masked source stays pending until unmasked
    wr(32'h0, 32'h1);
    irq = 3'b100; tick(); irq = 3'b000; tick(); tick();
    lreq("masked_noreq", 1'b0);
    lit("masked_pend", 32'h4, 32'h4);
    wr(32'h0, 32'h4);
    lreq("unmask_same_edge", 1'b0);
    tick();
    lreq("unmask_req", 1'b1);
    lvec("unmask_vec", 32'h120);

    // request survives clearing and masking of its source
    wr(32'h4, 32'h7);
    wr(32'h0, 32'h0);
    lreq("req_hold", 1'b1);
    lvec("vec_hold", 32'h120);
    lit("w1c_pend", 32'h4, 32'h0);
    lit("cur_hold", 32'hC, 32'hA);
    irq = 3'b010; bus.dmem_we = 1'b1; bus.dmem_addr = BASE + 32'h4; bus.dmem_wd = 32'h2;
    tick();
    irq = 3'b000; bus.dmem_we = 1'b0;
    lit("set_beats_w1c", 32'h4, 32'h2);
    pulse_ack();
    lit("ack2_insvc", 32'h8, 32'h4);
    lit("ack2_pend", 32'h4, 32'h2);

    // stray ack and eret
    pulse_ack();
    lit("ack_in_svc", 32'hC, 32'hA);
    lit("ack_in_svc_insvc", 32'h8, 32'h4);
    pulse_eret();
    lit("back_idle", 32'hC, 32'h2);
    pulse_eret();
    lit("eret_in_idle", 32'hC, 32'h2);
    lreq("eret_in_idle_req", 1'b0);
    wr(32'h0, 32'h7);
    tick();
    lreq("pend1_req", 1'b1);
    lvec("pend1_vec", 32'h110);

    // reset mid-request with IRQ0 held high through it
    irq = 3'b001; rst_n = 1'b0;
    tick();
    lreq("rst_mid_req", 1'b0);
    lvec("rst_mid_vec", 32'h0);
    lit("rst_mid_cur", 32'hC, 32'h0);
    lit("rst_mid_pend", 32'h4, 32'h0);
    rst_n = 1'b1;
    tick();
    lit("post_rst_pend", 32'h4, 32'h1);
    lreq("post_rst_masked", 1'b0);
    wr(32'h0, 32'h1);
    tick();
    lreq("held_req", 1'b1);
    lvec("held_vec", 32'h100);
    pulse_ack();
    pulse_eret();
    tick(); tick();
    lreq("held_once", 1'b0);
    lit("held_pend", 32'h4, 32'h0);
    irq = 3'b000;

    // randomized traffic, checked every cycle by the monitor
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 63) != 0);
      irq          = 3'($urandom);
      bus.irq_ack  = ($urandom_range(0, 2) == 0);
      bus.irq_eret = ($urandom_range(0, 2) == 0);
      bus.dmem_we  = ($urandom_range(0, 3) == 0);
      bus.dmem_wd  = $urandom;
      case ($urandom_range(0, 5))
        0: bus.dmem_addr = BASE;
        1: bus.dmem_addr = BASE + 32'h4;
        2: bus.dmem_addr = BASE + 32'h8;
        3: bus.dmem_addr = BASE + 32'hC;
        4: bus.dmem_addr = BASE + 32'($urandom_range(0, 15));
        default: bus.dmem_addr = $urandom;
      endcase
      tick();
    end
    rst_n = 1'b1; bus.dmem_we = 1'b0; bus.irq_ack = 1'b0; bus.irq_eret = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
